pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised program-counting unit: PC register, PC+1 incrementer and a DEPTH-entry hardware return-address stack.
- Replaces the single return-address register, so nested calls are supported.
- Sits at the front of the datapath. The control unit drives a per-cycle PC operation; the fetch path consumes pc.
- The interrupt/context-restore path pushes saved return addresses while the core is stalled.

Parameters:
- WIDTH, 16, width of PC, target and stack entries
- DEPTH, 8, return-address stack entries (power of two, >=2)
- RESET_VEC, 0, PC value after reset and after a pop on an empty stack

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; 0 = stall, PC and stack hold except restore_push
- op  in  3  PC operation: 000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, others HOLD
- cond  in  1  branch condition, used only by BRANCH
- target  in  WIDTH  jump/branch/call destination
- restore_push  in  1  push restore_data onto the stack (honoured only when en=0)
- restore_data  in  WIDTH  return address being restored
- clear_err  in  1  clears the sticky overflow and underflow flags
- pc  out  WIDTH  current PC
- pc_plus1  out  WIDTH  pc+1, combinational
- ra_top  out  WIDTH  top-of-stack entry; RESET_VEC when empty
- depth  out  clog2(DEPTH)+1  number of valid entries
- overflow  out  1  sticky: a push occurred while the stack was full
- underflow  out  1  sticky: a pop occurred while the stack was empty

Behaviour:
- Reset (reset_n=0, asynchronous, any time, including mid-operation):
  - pc=RESET_VEC, depth=0, overflow=0, underflow=0.
  - Stack contents need not be cleared; ra_top reads RESET_VEC because depth=0.
- Arithmetic: pc_plus1 = pc+1 modulo 2^WIDTH; all-ones wraps to 0 without any flag.
- All state updates occur on the rising clk edge when en=1 (single-cycle latency):
  - SEQ: pc<=pc_plus1.
  - JUMP: pc<=target.
  - BRANCH: pc<=target if cond=1, else pc<=pc_plus1.
  - CALL: push pc_plus1, then pc<=target.
  - RET: pop, then pc<=popped value.
  - HOLD (101/110/111): pc unchanged, stack unchanged.
- en=0: pc and all op-driven stack changes hold. If restore_push=1, restore_data is pushed (same push rules as below).
- restore_push with en=1 is ignored, with no state change from it.
- Stack organisation: circular buffer with a top pointer.
- Push when depth<DEPTH: write the entry and increment depth.
- Push when depth==DEPTH:
  - The new entry overwrites the oldest entry and becomes top.
  - depth stays at DEPTH; overflow<=1.
  - The CALL still jumps.
- Pop when depth>0: return the top entry and decrement depth; ra_top then shows the next entry.
- Pop when depth==0: pc<=RESET_VEC, depth stays 0, underflow<=1.
- Sticky flags stay set until clear_err=1 on a clock edge or reset.
- clear_err and a new error event in the same cycle: the flag ends set (the event wins).
- ra_top, depth and the flags are registered-state outputs and change only on a clk edge or reset.
- No combinational path from op/cond/target to pc; pc_plus1 depends only on pc.

Test Plan:
- Reset and sequencing, WIDTH=16: release reset_n, op=SEQ for 3 cycles -> pc=0,1,2,3; pc_plus1 is always pc+1; depth=0.
- Wrap: JUMP to 16'hFFFF, then SEQ -> pc=FFFF then 0000; no flag set.
- Nested call/return: at pc=5 CALL target=0x40; at 0x41 CALL target=0x80; then RET, RET.
  - Expected: pc=0x40, 0x41, 0x80, 0x42, 0x06.
  - ra_top shows 0x42 then 0x06; depth goes 1, 2, 1, 0.
- Overflow, DEPTH=8: 9 consecutive CALLs -> overflow=1, depth=8; 8 RETs return the newest 8 addresses in LIFO order.
  - A 9th RET -> pc=RESET_VEC, underflow=1.
  - clear_err then clears both flags.
- Stall and restore:
  - en=0 with op=CALL -> pc and depth unchanged.
  - en=0 with restore_push=1, restore_data=0x1234 -> depth+1, ra_top=0x1234.
  - en=1, op=RET -> pc=0x1234.
  - restore_push with en=1 -> ignored.
- Async reset mid-operation: assert reset_n low between clock edges after two CALLs -> pc=RESET_VEC and depth=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter, PC+1 incrementer and a DEPTH-entry
// circular return-address stack with sticky overflow/underflow flags.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   en                      advance enable (0 = stall; only restore_push acts)
//   op, cond, target        per-cycle PC operation, branch condition, destination
//   restore_push/_data      context-restore push, honoured only while stalled
//   clear_err               clears the sticky error flags
//   pc, pc_plus1            current PC and its combinational increment
//   ra_top, depth           top-of-stack entry and number of valid entries
//   overflow, underflow     sticky push-when-full / pop-when-empty flags
module pc_stack_unit #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     en,
   input  logic [2:0]               op,
   input  logic                     cond,
   input  logic [WIDTH-1:0]         target,
   input  logic                     restore_push,
   input  logic [WIDTH-1:0]         restore_data,
   input  logic                     clear_err,
   output logic [WIDTH-1:0]         pc,
   output logic [WIDTH-1:0]         pc_plus1,
   output logic [WIDTH-1:0]         ra_top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned DW = PW + 1;

   localparam logic [2:0] OP_SEQ    = 3'b000;
   localparam logic [2:0] OP_JUMP   = 3'b001;
   localparam logic [2:0] OP_BRANCH = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ra_top_q, ra_top_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             push, pop;
   logic [WIDTH-1:0] push_data;
   logic             full, empty;

   assign full     = (depth_q == DW'(DEPTH));
   assign empty    = (depth_q == '0);
   assign pc_plus1 = pc_q + WIDTH'(1);

   // Operation decode: selects next PC and whether the stack pushes or pops.
   always_comb begin
      pc_d      = pc_q;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = pc_plus1;
      if (en) begin
         case (op)
            OP_SEQ:    pc_d = pc_plus1;
            OP_JUMP:   pc_d = target;
            OP_BRANCH: pc_d = cond ? target : pc_plus1;
            OP_CALL: begin
               push = 1'b1;
               pc_d = target;
            end
            OP_RET: begin
               pop  = 1'b1;
               pc_d = empty ? RESET_VEC : mem_q[ptr_q];
            end
            default: pc_d = pc_q;
         endcase
      end else if (restore_push) begin
         push      = 1'b1;
         push_data = restore_data;
      end
   end

   // Stack pointer/depth/flags. A full push advances the pointer onto the
   // oldest slot, so the circular buffer overwrites it naturally.
   always_comb begin
      ptr_d       = ptr_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q & ~clear_err;
      underflow_d = underflow_q & ~clear_err;
      if (push) begin
         ptr_d = ptr_q + PW'(1);
         if (full) overflow_d = 1'b1;
         else      depth_d    = depth_q + DW'(1);
      end else if (pop) begin
         if (empty) begin
            underflow_d = 1'b1;
         end else begin
            ptr_d   = ptr_q - PW'(1);
            depth_d = depth_q - DW'(1);
         end
      end
   end

   // Next top-of-stack value, registered so ra_top only moves on an edge.
   always_comb begin
      ra_top_d = RESET_VEC;
      if (depth_d != '0) ra_top_d = push ? push_data : mem_q[ptr_d];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q        <= RESET_VEC;
         ra_top_q    <= RESET_VEC;
         depth_q     <= '0;
         ptr_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         ra_top_q    <= ra_top_d;
         depth_q     <= depth_d;
         ptr_q       <= ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Stack storage is not reset; depth alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[ptr_d] <= push_data;
   end

   assign pc        = pc_q;
   assign ra_top    = ra_top_q;
   assign depth     = depth_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and randomized checks of pc_stack_unit against a
// queue-based behavioural model of the PC and return-address stack.
module tb_pc_stack_unit;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 8;
   localparam logic [15:0] RVEC  = 16'h0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic [2:0]  op;
   logic        cond;
   logic [15:0] target;
   logic        restore_push;
   logic [15:0] restore_data;
   logic        clear_err;
   logic [15:0] pc, pc_plus1, ra_top;
   logic [3:0]  depth;
   logic        overflow, underflow;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model
   logic [15:0] m_pc;
   logic [15:0] m_stk[$];
   logic        m_ovf, m_unf;

   pc_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(RVEC)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .op(op), .cond(cond),
      .target(target), .restore_push(restore_push), .restore_data(restore_data),
      .clear_err(clear_err), .pc(pc), .pc_plus1(pc_plus1), .ra_top(ra_top),
      .depth(depth), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] m_top();
      return (m_stk.size() == 0) ? RVEC : m_stk[$];
   endfunction

   function automatic void m_push(input logic [15:0] v);
      if (m_stk.size() == DEPTH) begin
         void'(m_stk.pop_front());
         m_ovf = 1'b1;
      end
      m_stk.push_back(v);
   endfunction

   function automatic void m_step(input logic e, input logic [2:0] o, input logic c,
                                  input logic [15:0] t, input logic rp,
                                  input logic [15:0] rd, input logic ce);
      if (ce) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (e) begin
         case (o)
            3'd0: m_pc = m_pc + 16'd1;
            3'd1: m_pc = t;
            3'd2: m_pc = c ? t : m_pc + 16'd1;
            3'd3: begin m_push(m_pc + 16'd1); m_pc = t; end
            3'd4: begin
               if (m_stk.size() == 0) begin
                  m_pc  = RVEC;
                  m_unf = 1'b1;
               end else begin
                  m_pc = m_stk.pop_back();
               end
            end
            default: ;
         endcase
      end else if (rp) begin
         m_push(rd);
      end
   endfunction

   // Drive one cycle at the falling edge, advance the model, sample 1 after the rising edge.
   task automatic cycle(input logic e, input logic [2:0] o, input logic c,
                        input logic [15:0] t, input logic rp = 1'b0,
                        input logic [15:0] rd = 16'h0, input logic ce = 1'b0);
      @(negedge clk);
      en = e; op = o; cond = c; target = t;
      restore_push = rp; restore_data = rd; clear_err = ce;
      m_step(e, o, c, t, rp, rd, ce);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      en = 1'b1; op = 3'd5; cond = 1'b0; target = '0;
      restore_push = 1'b0; restore_data = '0; clear_err = 1'b0;
      m_pc = RVEC; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_total++; if (pc !== RVEC) $display("FAIL reset_pc got %h exp %h", pc, RVEC); else n_pass++;
      n_total++; if (depth !== 4'd0) $display("FAIL reset_depth got %0d exp 0", depth); else n_pass++;
      n_total++; if (ra_top !== RVEC) $display("FAIL reset_ra_top got %h exp %h", ra_top, RVEC); else n_pass++;
      n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); else n_pass++;
   endtask

   task automatic test_seq();
      for (int i = 1; i <= 3; i++) begin
         cycle(1'b1, 3'd0, 1'b0, 16'h0);
         n_total++; if (pc !== 16'(i)) $display("FAIL seq_pc%0d got %h exp %h", i, pc, 16'(i)); else n_pass++;
         n_total++; if (pc_plus1 !== 16'(i + 1)) $display("FAIL seq_plus1_%0d got %h exp %h", i, pc_plus1, 16'(i + 1)); else n_pass++;
         n_total++; if (depth !== 4'd0) $display("FAIL seq_depth%0d got %0d exp 0", i, depth); else n_pass++;
      end
   endtask

   task automatic test_wrap();
      cycle(1'b1, 3'd1, 1'b0, 16'hFFFF);
      n_total++; if (pc !== 16'hFFFF) $display("FAIL wrap_jump got %h exp ffff", pc); else n_pass++;
      n_total++; if (pc_plus1 !== 16'h0000) $display("FAIL wrap_plus1 got %h exp 0000", pc_plus1); else n_pass++;
      cycle(1'b1, 3'd0, 1'b0, 16'h0);
      n_total++; if (pc !== 16'h0000) $display("FAIL wrap_seq got %h exp 0000", pc); else n_pass++;
      n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL wrap_flags got %b exp 00", {overflow, underflow}); else n_pass++;
   endtask

   task automatic test_nested();
      logic [15:0] exp_pc[5]  = '{16'h40, 16'h41, 16'h80, 16'h42, 16'h06};
      logic [15:0] exp_top[5] = '{16'h06, 16'h06, 16'h42, 16'h06, RVEC};
      logic [3:0]  exp_dep[5] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd0};
      logic [2:0]  ops[5]     = '{3'd3, 3'd0, 3'd3, 3'd4, 3'd4};
      logic [15:0] tgts[5]    = '{16'h40, 16'h0, 16'h80, 16'h0, 16'h0};
      do_reset();
      cycle(1'b1, 3'd1, 1'b0, 16'h0005);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, ops[i], 1'b0, tgts[i]);
         n_total++; if (pc !== exp_pc[i]) $display("FAIL nest_pc%0d got %h exp %h", i, pc, exp_pc[i]); else n_pass++;
         n_total++; if (ra_top !== exp_top[i]) $display("FAIL nest_top%0d got %h exp %h", i, ra_top, exp_top[i]); else n_pass++;
         n_total++; if (depth !== exp_dep[i]) $display("FAIL nest_depth%0d got %0d exp %0d", i, depth, exp_dep[i]); else n_pass++;
      end
   endtask

   task automatic test_overflow();
      logic [15:0] pushed[9];
      logic [15:0] cur;
      do_reset();
      cur = RVEC;
      for (int i = 0; i < 9; i++) begin
         pushed[i] = cur + 16'd1;
         cur = 16'h0100 + 16'(i * 16);
         cycle(1'b1, 3'd3, 1'b0, cur);
      end
      n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else n_pass++;
      n_total++; if (depth !== 4'd8) $display("FAIL ovf_depth got %0d exp 8", depth); else n_pass++;
      n_total++; if (pc !== 16'h0180) $display("FAIL ovf_pc got %h exp 0180", pc); else n_pass++;
      for (int i = 8; i >= 1; i--) begin
         cycle(1'b1, 3'd4, 1'b0, 16'h0);
         n_total++; if (pc !== pushed[i]) $display("FAIL ovf_ret%0d got %h exp %h", i, pc, pushed[i]); else n_pass++;
      end
      n_total++; if (underflow !== 1'b0) $display("FAIL ovf_no_unf got %b exp 0", underflow); else n_pass++;
      cycle(1'b1, 3'd4, 1'b0, 16'h0);
      n_total++; if (pc !== RVEC) $display("FAIL unf_pc got %h exp %h", pc, RVEC); else n_pass++;
      n_total++; if (underflow !== 1'b1) $display("FAIL unf_flag got %b exp 1", underflow); else n_pass++;
      n_total++; if (depth !== 4'd0) $display("FAIL unf_depth got %0d exp 0", depth); else n_pass++;
      cycle(1'b1, 3'd5, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      n_total++; if ({overflow, underflow} !== 2'b00) $display("FAIL clear_flags got %b exp 00", {overflow, underflow}); else n_pass++;
      // clear_err alongside a fresh underflow: the event wins
      cycle(1'b1, 3'd4, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      n_total++; if (underflow !== 1'b1) $display("FAIL clear_vs_event got %b exp 1", underflow); else n_pass++;
   endtask

   task automatic test_stall_restore();
      do_reset();
      cycle(1'b1, 3'd1, 1'b0, 16'h0020);
      cycle(1'b1, 3'd3, 1'b0, 16'h0030);
      cycle(1'b0, 3'd3, 1'b0, 16'h0099);
      n_total++; if (pc !== 16'h0030) $display("FAIL stall_pc got %h exp 0030", pc); else n_pass++;
      n_total++; if (depth !== 4'd1) $display("FAIL stall_depth got %0d exp 1", depth); else n_pass++;
      cycle(1'b0, 3'd0, 1'b0, 16'h0, 1'b1, 16'h1234);
      n_total++; if (depth !== 4'd2) $display("FAIL restore_depth got %0d exp 2", depth); else n_pass++;
      n_total++; if (ra_top !== 16'h1234) $display("FAIL restore_top got %h exp 1234", ra_top); else n_pass++;
      n_total++; if (pc !== 16'h0030) $display("FAIL restore_pc got %h exp 0030", pc); else n_pass++;
      cycle(1'b1, 3'd4, 1'b0, 16'h0);
      n_total++; if (pc !== 16'h1234) $display("FAIL restore_ret got %h exp 1234", pc); else n_pass++;
      cycle(1'b1, 3'd5, 1'b0, 16'h0, 1'b1, 16'h5555);
      n_total++; if (depth !== 4'd1) $display("FAIL rp_ignored_depth got %0d exp 1", depth); else n_pass++;
      n_total++; if (ra_top !== 16'h0021) $display("FAIL rp_ignored_top got %h exp 0021", ra_top); else n_pass++;
      n_total++; if (pc !== 16'h1234) $display("FAIL hold_pc got %h exp 1234", pc); else n_pass++;
   endtask

   task automatic test_random();
      logic e, c, rp, ce;
      logic [2:0]  o;
      logic [15:0] t, rd;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         e  = ($urandom_range(0, 9) != 0);
         o  = ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
         c  = 1'($urandom);
         t  = 16'($urandom);
         rp = 1'($urandom);
         rd = 16'($urandom);
         ce = ($urandom_range(0, 15) == 0);
         cycle(e, o, c, t, rp, rd, ce);
         n_total++;
         if (pc !== m_pc || pc_plus1 !== m_pc + 16'd1 || ra_top !== m_top() ||
             depth !== 4'(m_stk.size()) || overflow !== m_ovf || underflow !== m_unf)
            $display("FAIL rand%0d got pc=%h p1=%h top=%h d=%0d o=%b u=%b exp pc=%h p1=%h top=%h d=%0d o=%b u=%b",
                     i, pc, pc_plus1, ra_top, depth, overflow, underflow,
                     m_pc, m_pc + 16'd1, m_top(), m_stk.size(), m_ovf, m_unf);
         else
            n_pass++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1'b1, 3'd3, 1'b0, 16'h0010);
      cycle(1'b1, 3'd3, 1'b0, 16'h0020);
      n_total++; if (depth !== 4'd2) $display("FAIL areset_pre_depth got %0d exp 2", depth); else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_total++; if (pc !== RVEC) $display("FAIL areset_pc got %h exp %h", pc, RVEC); else n_pass++;
      n_total++; if (depth !== 4'd0) $display("FAIL areset_depth got %0d exp 0", depth); else n_pass++;
      n_total++; if (ra_top !== RVEC) $display("FAIL areset_top got %h exp %h", ra_top, RVEC); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      en = 1'b0; op = 3'd5; cond = 1'b0; target = '0;
      restore_push = 1'b0; restore_data = '0; clear_err = 1'b0;
      test_reset();
      test_seq();
      test_wrap();
      test_nested();
      test_overflow();
      test_stall_restore();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
